// File: rtl/az_mem_responder_if.sv
// rtl/az_mem_responder_if.sv - command/response bus between an initiator and az_mem_responder
interface az_mem_responder_if;
  logic [21:0] az_addr;
  logic [1:0]  az_be_n;
  logic [15:0] az_data;
  logic        az_rd_n;
  logic        az_wr_n;
  logic [15:0] za_data;
  logic        za_valid;
  logic        za_waitrequest;

  modport master (
    output az_addr, az_be_n, az_data, az_rd_n, az_wr_n,
    input  za_data, za_valid, za_waitrequest
  );

  modport slave (
    input  az_addr, az_be_n, az_data, az_rd_n, az_wr_n,
    output za_data, za_valid, za_waitrequest
  );
endinterface

// File: rtl/az_mem_responder.sv
// rtl/az_mem_responder.sv - 16-bit word memory responder with pipelined reads and periodic stall bursts
module az_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int RD_LATENCY  = 3,
  parameter int WAIT_EVERY  = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  az_mem_responder_if.slave    bus,
  output logic [15:0]          o_rd_count,
  output logic [15:0]          o_wr_count,
  output logic                 o_proto_err
);

  localparam int         DEPTH       = 1 << ADDR_W;
  localparam logic [7:0] EVERY_LAST  = 8'((WAIT_EVERY > 0) ? WAIT_EVERY - 1 : 0);
  localparam logic [3:0] CYCLES_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_STALL} state_t;

  state_t      state, state_n;
  logic [7:0]  cmd_cnt, cmd_cnt_n;
  logic [3:0]  stall_cnt, stall_cnt_n;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [15:0]       rd_word;
  logic              cmd_req;
  logic              cmd_event;
  logic              rd_accept;
  logic              wr_accept;
  logic              proto_hit;
  logic              unused_addr_hi;

  logic              pipe_v [RD_LATENCY];
  logic [15:0]       pipe_d [RD_LATENCY];

  assign idx            = bus.az_addr[ADDR_W-1:0];
  assign unused_addr_hi = ^bus.az_addr[21:ADDR_W];
  assign rd_word        = mem[idx];

  // A both-low cycle is not a memory access but still paces the stall counter.
  assign cmd_req   = ~bus.az_rd_n | ~bus.az_wr_n;
  assign cmd_event = cmd_req & ~bus.za_waitrequest;
  assign rd_accept = cmd_event & ~bus.az_rd_n &  bus.az_wr_n;
  assign wr_accept = cmd_event &  bus.az_rd_n & ~bus.az_wr_n;
  assign proto_hit = cmd_event & ~bus.az_rd_n & ~bus.az_wr_n;

  // Memory contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      if (!bus.az_be_n[0]) mem[idx][7:0]  <= bus.az_data[7:0];
      if (!bus.az_be_n[1]) mem[idx][15:8] <= bus.az_data[15:8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= 16'h0000;
      end
    end else begin
      pipe_v[0] <= rd_accept;
      if (rd_accept) pipe_d[0] <= rd_word;
      // Data only moves with a valid token, so the last stage holds za_data between returns.
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign bus.za_valid = pipe_v[RD_LATENCY-1];
  assign bus.za_data  = pipe_d[RD_LATENCY-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rd_count  <= 16'h0000;
      o_wr_count  <= 16'h0000;
      o_proto_err <= 1'b0;
    end else begin
      if (rd_accept) o_rd_count <= o_rd_count + 16'h0001;
      if (wr_accept) o_wr_count <= o_wr_count + 16'h0001;
      if (proto_hit) o_proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_cnt   <= 8'h00;
      stall_cnt <= 4'h0;
    end else begin
      state     <= state_n;
      cmd_cnt   <= cmd_cnt_n;
      stall_cnt <= stall_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    cmd_cnt_n   = cmd_cnt;
    stall_cnt_n = stall_cnt;
    case (state)
      ST_IDLE: begin
        if (cmd_event && (WAIT_EVERY != 0)) begin
          if (cmd_cnt == EVERY_LAST) begin
            state_n     = ST_STALL;
            cmd_cnt_n   = 8'h00;
            stall_cnt_n = 4'h0;
          end else begin
            cmd_cnt_n = cmd_cnt + 8'h01;
          end
        end
      end
      ST_STALL: begin
        if (stall_cnt == CYCLES_LAST) state_n = ST_IDLE;
        else                          stall_cnt_n = stall_cnt + 4'h1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.za_waitrequest = reset | (state == ST_STALL);
  end

endmodule
